// File: rtl/cnn_pkg.sv
// Shared CNN datapath defaults and helpers for the pooling stages.
package cnn_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 8;
  localparam int unsigned MAP_SIZE_DEFAULT   = 16;

  // Position of a pixel inside its 2x2 pooling window: {row[0], col[0]}.
  typedef enum logic [1:0] {
    POS_EVEN_EVEN = 2'b00,
    POS_EVEN_ODD  = 2'b01,
    POS_ODD_EVEN  = 2'b10,
    POS_ODD_ODD   = 2'b11
  } pool_pos_e;

  // Signed max on sign-extended operands; callers truncate back to their width.
  function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    return (a < b) ? b : a;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row line buffer holding even-row partial maxima, one entry per window column.
module pool_line_buf #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AW         = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/maxpool_stream.sv
// Streaming 2x2 / stride-2 signed max-pool over a MAP_SIZE x MAP_SIZE raster stream.
module maxpool_stream
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned MAP_SIZE   = MAP_SIZE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int unsigned CW    = (MAP_SIZE > 1) ? $clog2(MAP_SIZE) : 1;
  localparam int unsigned DEPTH = MAP_SIZE / 2;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(MAP_SIZE - 1);

  logic [CW-1:0]         col_q, col_d;
  logic [CW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;

  logic                  in_fire;
  pool_pos_e             pos;
  logic [DATA_WIDTH-1:0] pair_max;
  logic                  lbuf_we;
  logic [AW-1:0]         lbuf_addr;
  logic [DATA_WIDTH-1:0] lbuf_rdata;

  function automatic logic [DATA_WIDTH-1:0] pmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return DATA_WIDTH'(smax(32'($signed(a)), 32'($signed(b))));
  endfunction

  // Stall on any pending output so the counters never run ahead of the output register.
  assign s_ready   = rst_n && !clear && (!m_valid_q || m_ready);
  assign in_fire   = s_valid && s_ready;
  assign pos       = pool_pos_e'({row_q[0], col_q[0]});
  assign pair_max  = pmax(hold_q, s_data);
  assign lbuf_addr = AW'(col_q >> 1);

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    hold_d    = hold_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    lbuf_we   = 1'b0;

    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    if (in_fire) begin
      if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      case (pos)
        POS_EVEN_EVEN, POS_ODD_EVEN: hold_d = s_data;
        POS_EVEN_ODD:                lbuf_we = 1'b1;
        POS_ODD_ODD: begin
          m_valid_d = 1'b1;
          m_data_d  = pmax(lbuf_rdata, pair_max);
          m_last_d  = (row_q == LAST_IDX) && (col_q == LAST_IDX);
        end
        default: ;
      endcase
    end

    if (clear) begin
      col_d     = '0;
      row_d     = '0;
      m_valid_d = 1'b0;
      m_data_d  = '0;
      m_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  pool_line_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_line_buf (
    .clk  (clk),
    .we   (lbuf_we),
    .waddr(lbuf_addr),
    .wdata(pair_max),
    .raddr(lbuf_addr),
    .rdata(lbuf_rdata)
  );

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

endmodule

// File: doc/maxpool_stream.md
# maxpool_stream

Streaming 2x2/stride-2 max-pooling stage directly downstream of the ReLU/requantise stage. It consumes the 8-bit activation map one pixel per beat in raster order and emits one pooled pixel per 2x2 window. Its output also streams in raster order, as a (MAP_SIZE/2)x(MAP_SIZE/2) map for the next convolution layer. A half-row line buffer holds the even-row partial maxima, so no full-frame storage is needed.

## Interface
- DATA_WIDTH, 8: activation width (signed two's complement); matches ReLU OUT_WIDTH.
- MAP_SIZE, 16: input map edge length; must be even and at least 2.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous frame abort/restart.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input accept.
- s_data  in  DATA_WIDTH  input pixel, signed.
- m_valid  out  1  pooled pixel valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  pooled pixel, signed.
- m_last  out  1  marks the final pooled pixel of a frame.

## Operation
- An input beat transfers on `s_valid && s_ready`. An output beat transfers on `m_valid && m_ready`.
- Counters: `col` and `row`, each 0..MAP_SIZE-1, each `$clog2(MAP_SIZE)` bits wide. `col` advances on every input beat. On wrap at MAP_SIZE-1, `col` returns to 0 and `row` advances. `row` wraps at MAP_SIZE-1 to 0, which starts the next frame.
- All comparisons are signed. max(a,b) returns `b` when `a < b`, otherwise `a`. On ties the result is identical either way.
- Even row, even col: latch the pixel into `hold`.
- Even row, odd col: write `max(hold, s_data)` to `lbuf[col>>1]`.
- Odd row, even col: latch the pixel into `hold`.
- Odd row, odd col: load the output register with `max(lbuf[col>>1], max(hold, s_data))` and set `m_valid`. Set `m_last` when this is the last input pixel of the frame (`row==MAP_SIZE-1 && col==MAP_SIZE-1`).
- Frame boundaries need no gap; frame N+1 may begin on the cycle after frame N's last pixel.
- `clear` has the same effect as reset, but synchronous:
  - counters go to 0;
  - `m_valid`, `m_last` and `m_data` go to 0;
  - any partial frame and any pending output are discarded.
- `clear` wins over a simultaneous input beat. `s_ready` is low while `clear` is high.
- `lbuf` and `hold` are not reset. Every entry is written before it is read in every frame.

## Timing
- Reset values: `s_ready`=0 while `rst_n` is low; `m_valid`=0, `m_data`=0, `m_last`=0.
- Counters and state registers are 0 after reset.
- `s_ready = !clear && (!m_valid || m_ready)`, combinational and registered-free. Throughput is 1 pixel/cycle while downstream is ready.
- Latency: the output beat appears one cycle after the input beat that completes the window (odd row, odd col).
- `m_data` and `m_last` stay stable while `m_valid && !m_ready`.
- `s_ready` drops during that stall even for beats that would not produce output. This keeps the counters aligned, and the cost is accepted.
- `m_valid` clears after a handshake unless a new window completes in the same cycle (back-to-back outputs are possible only with 2-pixel spacing, so never in the same cycle).
- Reset asserted mid-frame clears everything asynchronously. The next accepted pixel is treated as (row 0, col 0).

## Structure
- Shared package `cnn_pkg`: DATA_WIDTH and MAP_SIZE defaults, plus the signed max function, shared with the future pool variants.
- Sub-module `pool_line_buf`: MAP_SIZE/2 x DATA_WIDTH register array with one synchronous write port and one combinational read port, addressed by `col>>1`.
- The top level holds the counters, `hold`, the output register and the handshake logic.

## Test plan
- MAP_SIZE=4 ramp: pixel = row*4+col, continuous valid, m_ready=1 -> outputs 5, 7, 13, 15, with m_last only on 15. Each output appears one cycle after input pixels 5, 7, 13 and 15 respectively.
- MAP_SIZE=4:
  - Frame of zeros except (0,0)=8'h7f -> outputs 7f, 00, 00, 00.
  - Window {-3,-1,-2,-5} (8'hfd, 8'hff, 8'hfe, 8'hfb) -> 8'hff.
  - All 8'h80 -> 8'h80.
- Backpressure: hold m_ready=0 for 5 cycles while the first output is pending -> s_ready=0 throughout and m_data=5 stable. After release the sequence continues 7, 13, 15 with no loss or duplication.
- Clear and reset mid-frame: assert clear after 6 beats, then send the ramp -> 5, 7, 13, 15. Repeat with rst_n pulsed low mid-frame -> same result, and all outputs are 0 during reset.
- Default MAP_SIZE=16: two back-to-back random frames (values 0..127) compared against a reference model -> 64 outputs per frame. m_last is set only on outputs 64 and 128. Random m_ready throttling gives no mismatches.
